// File: rtl/id_ex_stage.sv
// RV32I decode / ID-EX pipeline register with valid-ready handshake on both sides.
// Optional write-back forwarding into the operand muxes is enabled by defining FWD_EN.
module id_ex_stage #(
  parameter logic [31:0] RESET_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        flush,
`ifdef FWD_EN
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [6:0]  opcode_reg,
  output logic [2:0]  funct3_reg,
  output logic [6:0]  funct7_reg,
  output logic [31:0] srcA,
  output logic [31:0] srcB,
  output logic [31:0] imm,
  output logic [4:0]  rd,
  output logic [31:0] pc_out,
  output logic        illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Control-field decode of the idle instruction, shown after reset, flush and illegal opcodes
  localparam logic [6:0] RST_OP = RESET_INSTR[6:0];
  localparam logic [2:0] RST_F3 = (RST_OP == OPC_LUI || RST_OP == OPC_AUIPC || RST_OP == OPC_JAL)
                                  ? 3'd0 : RESET_INSTR[14:12];
  localparam logic [6:0] RST_F7 = (RST_OP == OPC_OP ||
                                   (RST_OP == OPC_OPIMM &&
                                    (RESET_INSTR[14:12] == 3'b001 || RESET_INSTR[14:12] == 3'b101)))
                                  ? RESET_INSTR[31:25] : 7'd0;

  logic        r_valid;
  logic [6:0]  r_opcode;
  logic [2:0]  r_funct3;
  logic [6:0]  r_funct7;
  logic [31:0] r_srca;
  logic [31:0] r_srcb;
  logic [31:0] r_imm;
  logic [4:0]  r_rd;
  logic [31:0] r_pc;
  logic        r_illegal;

  logic        w_accept;
  logic [6:0]  w_op;
  logic [2:0]  w_f3;
  logic [31:0] w_rs1;
  logic [31:0] w_rs2;
  logic [31:0] w_imm_raw;
  logic        w_legal;
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [31:0] w_srca;
  logic [31:0] w_srcb;
  logic [31:0] w_imm;
  logic [4:0]  w_rd;

  assign w_op     = instr[6:0];
  assign w_f3     = instr[14:12];
  assign in_ready = !rst && (!r_valid || out_ready);
  assign w_accept = in_valid && in_ready;

`ifdef FWD_EN
  // A result being written back this cycle overrides the stale register-file read
  assign w_rs1 = (wb_we && wb_rd != 5'd0 && wb_rd == instr[19:15]) ? wb_data : rs1_data;
  assign w_rs2 = (wb_we && wb_rd != 5'd0 && wb_rd == instr[24:20]) ? wb_data : rs2_data;
`else
  assign w_rs1 = rs1_data;
  assign w_rs2 = rs2_data;
`endif

  // Immediate extraction per instruction format
  always_comb begin
    w_imm_raw = 32'd0;
    w_legal   = 1'b1;
    unique case (w_op)
      OPC_OP:                         w_imm_raw = 32'd0;
      OPC_OPIMM, OPC_LOAD, OPC_JALR:  w_imm_raw = {{20{instr[31]}}, instr[31:20]};
      OPC_STORE:                      w_imm_raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OPC_BRANCH:                     w_imm_raw = {{19{instr[31]}}, instr[31], instr[7],
                                                   instr[30:25], instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:             w_imm_raw = {instr[31:12], 12'd0};
      OPC_JAL:                        w_imm_raw = {{11{instr[31]}}, instr[31], instr[19:12],
                                                   instr[20], instr[30:21], 1'b0};
      default:                        w_legal   = 1'b0;
    endcase
  end

  // Operand selection and control-field decode
  always_comb begin
    w_opcode = w_op;
    w_funct3 = w_f3;
    w_funct7 = 7'd0;
    w_srca   = w_rs1;
    w_srcb   = w_rs2;
    w_imm    = w_imm_raw;
    w_rd     = instr[11:7];
    case (w_op)
      OPC_OP:    w_funct7 = instr[31:25];
      OPC_OPIMM: begin
        w_srcb = w_imm_raw;
        if (w_f3 == 3'b001 || w_f3 == 3'b101) w_funct7 = instr[31:25];
      end
      OPC_LOAD:  w_srcb = w_imm_raw;
      OPC_STORE: begin
        w_srcb = w_imm_raw;
        w_rd   = 5'd0;
      end
      OPC_BRANCH: w_rd = 5'd0;
      OPC_LUI: begin
        w_srca   = 32'd0;
        w_srcb   = w_imm_raw;
        w_funct3 = 3'd0;
      end
      OPC_AUIPC: begin
        w_srca   = pc;
        w_srcb   = w_imm_raw;
        w_funct3 = 3'd0;
      end
      OPC_JAL: begin
        w_srca   = pc;
        w_srcb   = 32'd4;
        w_funct3 = 3'd0;
      end
      OPC_JALR: begin
        w_srca = pc;
        w_srcb = 32'd4;
      end
      default: begin
        w_opcode = RST_OP;
        w_funct3 = RST_F3;
        w_srca   = 32'd0;
        w_srcb   = 32'd0;
        w_imm    = 32'd0;
        w_rd     = 5'd0;
      end
    endcase
  end

  // Pipeline register: flush behaves like reset and wins over a same-cycle accept
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_valid   <= 1'b0;
      r_opcode  <= RST_OP;
      r_funct3  <= RST_F3;
      r_funct7  <= RST_F7;
      r_srca    <= 32'd0;
      r_srcb    <= 32'd0;
      r_imm     <= 32'd0;
      r_rd      <= 5'd0;
      r_pc      <= 32'd0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_opcode  <= w_opcode;
      r_funct3  <= w_funct3;
      r_funct7  <= w_legal ? w_funct7 : RST_F7;
      r_srca    <= w_srca;
      r_srcb    <= w_srcb;
      r_imm     <= w_imm;
      r_rd      <= w_rd;
      r_pc      <= pc;
      r_illegal <= !w_legal;
    end else if (out_ready) begin
      r_valid   <= 1'b0;
    end
  end

  assign out_valid  = r_valid;
  assign opcode_reg = r_opcode;
  assign funct3_reg = r_funct3;
  assign funct7_reg = r_funct7;
  assign srcA       = r_srca;
  assign srcB       = r_srcb;
  assign imm        = r_imm;
  assign rd         = r_rd;
  assign pc_out     = r_pc;
  assign illegal    = r_illegal;

endmodule
